seg7_scan_driver: RTL

Time-multiplexed driver for a bank of common-anode 7-segment digits. Latches a packed multi-digit BCD/hex value and scans one digit per refresh tick with a configurable digit count and refresh period. Adds leading-zero blanking, per-digit decimal points and a tear-free frame-boundary update. It sits between counter/timer datapaths and the board's segment/digit-select pins, and supersedes the single-digit combinational decoder.

---
 rtl/seg7_pkg.sv | 32 +++
 rtl/seg7_glyph_decode.sv | 44 ++++
 rtl/seg7_scan_driver.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Glyph table and scan-state type shared by the 7-segment scan driver and its decoder.
package seg7_pkg;

  typedef logic [6:0] seg7_t;

  // Active-low {g,f,e,d,c,b,a}
  localparam seg7_t SEG_BLANK = 7'b1111111;
  localparam seg7_t SEG_DASH  = 7'b0111111;

  localparam seg7_t SEG_0 = 7'b1000000;
  localparam seg7_t SEG_1 = 7'b1111001;
  localparam seg7_t SEG_2 = 7'b0100100;
  localparam seg7_t SEG_3 = 7'b0110000;
  localparam seg7_t SEG_4 = 7'b0011001;
  localparam seg7_t SEG_5 = 7'b0010010;
  localparam seg7_t SEG_6 = 7'b0000010;
  localparam seg7_t SEG_7 = 7'b1111000;
  localparam seg7_t SEG_8 = 7'b0000000;
  localparam seg7_t SEG_9 = 7'b0010000;
  localparam seg7_t SEG_A = 7'b0001000;
  localparam seg7_t SEG_B = 7'b0000011;
  localparam seg7_t SEG_C = 7'b1000110;
  localparam seg7_t SEG_D = 7'b0100001;
  localparam seg7_t SEG_E = 7'b0000110;
  localparam seg7_t SEG_F = 7'b0001110;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } scan_state_e;

endpackage

// File: rtl/seg7_glyph_decode.sv
// Nibble to active-low 7-segment glyph. Hex letters A..F exist only when SEG7_HEX_EN
// is defined; otherwise hex_mode is ignored and codes 10..15 show a dash.
module seg7_glyph_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       hex_mode,
  output logic [6:0] glyph_c
);

`ifdef SEG7_HEX_EN
  logic hex_sel_c;
  assign hex_sel_c = hex_mode;
`else
  logic hex_sel_c;
  logic unused_hex_mode;
  assign hex_sel_c       = 1'b0;
  assign unused_hex_mode = hex_mode;
`endif

  always_comb begin
    glyph_c = SEG_DASH;
    case (nibble)
      4'h0: glyph_c = SEG_0;
      4'h1: glyph_c = SEG_1;
      4'h2: glyph_c = SEG_2;
      4'h3: glyph_c = SEG_3;
      4'h4: glyph_c = SEG_4;
      4'h5: glyph_c = SEG_5;
      4'h6: glyph_c = SEG_6;
      4'h7: glyph_c = SEG_7;
      4'h8: glyph_c = SEG_8;
      4'h9: glyph_c = SEG_9;
      4'hA: glyph_c = hex_sel_c ? SEG_A : SEG_DASH;
      4'hB: glyph_c = hex_sel_c ? SEG_B : SEG_DASH;
      4'hC: glyph_c = hex_sel_c ? SEG_C : SEG_DASH;
      4'hD: glyph_c = hex_sel_c ? SEG_D : SEG_DASH;
      4'hE: glyph_c = hex_sel_c ? SEG_E : SEG_DASH;
      4'hF: glyph_c = hex_sel_c ? SEG_F : SEG_DASH;
      default: glyph_c = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment scanner with leading-zero blanking, per-digit
// decimal points and frame-boundary value commit. Hex glyphs compiled in by SEG7_HEX_EN.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned DIV    = 50000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                load,
  input  logic [4*DIGITS-1:0] value,
  input  logic [DIGITS-1:0]   dp,
  input  logic                blank_lz,
  input  logic                hex_mode,
  output logic [6:0]          seg,
  output logic                seg_dp,
  output logic [DIGITS-1:0]   an,
  output logic                frame_done
);

  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned CNT_W = $clog2(DIV);
  localparam int unsigned VAL_W = 4 * DIGITS;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  scan_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [VAL_W-1:0]  pend_val_q, pend_val_d;
  logic [DIGITS-1:0] pend_dp_q, pend_dp_d;
  logic [VAL_W-1:0]  disp_val_q, disp_val_d;
  logic [DIGITS-1:0] disp_dp_q, disp_dp_d;
  logic [DIGITS-1:0] an_q, an_d;
  seg7_t             seg_q, seg_d;
  logic              seg_dp_q, seg_dp_d;
  logic              frame_done_q, frame_done_d;

  logic              tick_c;
  logic [3:0]        sel_nib_c;
  logic              sel_dp_c;
  logic              sel_blank_c;
  logic [DIGITS-1:0] sel_an_c;
  logic [DIGITS-1:0] lz_blank_c;
  logic              all_zero_c;
  logic [6:0]        glyph_c;

  // Scan sequencing: the first tick out of idle shows digit 0 without advancing;
  // display only takes the pending value on the DIGITS-1 -> 0 wrap.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    pend_val_d = pend_val_q;
    pend_dp_d  = pend_dp_q;
    disp_val_d = disp_val_q;
    disp_dp_d  = disp_dp_q;
    tick_c     = 1'b0;

    if (load) begin
      pend_val_d = value;
      pend_dp_d  = dp;
    end

    if (!en) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      tick_c = (cnt_q == CNT_LAST);
      cnt_d  = tick_c ? '0 : cnt_q + CNT_W'(1);
      if (tick_c) begin
        case (state_q)
          ST_IDLE: begin
            state_d = ST_SCAN;
            idx_d   = '0;
          end
          ST_SCAN: begin
            if (idx_q == IDX_LAST) begin
              idx_d      = '0;
              disp_val_d = load ? value : pend_val_q;
              disp_dp_d  = load ? dp : pend_dp_q;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end
  end

  // Digit about to be shown: nibble, dp request, blanking and anode pattern.
  always_comb begin
    sel_nib_c   = 4'h0;
    sel_dp_c    = 1'b0;
    sel_blank_c = 1'b0;
    sel_an_c    = '1;
    lz_blank_c  = '0;
    all_zero_c  = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      all_zero_c    = all_zero_c & (disp_val_d[4*i +: 4] == 4'h0);
      lz_blank_c[i] = blank_lz & all_zero_c;
    end
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_d == IDX_W'(i)) begin
        sel_nib_c   = disp_val_d[4*i +: 4];
        sel_dp_c    = disp_dp_d[i];
        sel_blank_c = lz_blank_c[i];
        sel_an_c[i] = 1'b0;
      end
    end
  end

  seg7_glyph_decode u_glyph (
    .nibble   (sel_nib_c),
    .hex_mode (hex_mode),
    .glyph_c  (glyph_c)
  );

  // Output pins only change on a tick (new slot) or when disabled.
  always_comb begin
    an_d         = an_q;
    seg_d        = seg_q;
    seg_dp_d     = seg_dp_q;
    frame_done_d = 1'b0;
    if (!en) begin
      an_d     = '1;
      seg_d    = SEG_BLANK;
      seg_dp_d = 1'b1;
    end else if (tick_c) begin
      frame_done_d = (idx_d == IDX_LAST);
      if (sel_blank_c) begin
        an_d     = '1;
        seg_d    = SEG_BLANK;
        seg_dp_d = 1'b1;
      end else begin
        an_d     = sel_an_c;
        seg_d    = glyph_c;
        seg_dp_d = ~sel_dp_c;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      pend_val_q   <= '0;
      pend_dp_q    <= '0;
      disp_val_q   <= '0;
      disp_dp_q    <= '0;
      an_q         <= '1;
      seg_q        <= SEG_BLANK;
      seg_dp_q     <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      pend_val_q   <= pend_val_d;
      pend_dp_q    <= pend_dp_d;
      disp_val_q   <= disp_val_d;
      disp_dp_q    <= disp_dp_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      seg_dp_q     <= seg_dp_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign seg_dp     = seg_dp_q;
  assign frame_done = frame_done_q;

endmodule
